acq_frame_scheduler: RTL

Sequences the dual-channel Intan SPI master (`spi_master_hs`) for continuous acquisition.
- Holds the master in reset while idle, then releases and triggers it.
- Detects each end-of-conversion, discards the pipeline-lag words, tags samples with the true channel and packs them into framed A/B words.
- Buffers words in a small FIFO behind a valid/ready stream to the host-side packetizer.
- Stops cleanly on a frame boundary.

---
 rtl/acq_pkg.sv | 27 ++
 rtl/acq_fifo.sv | 51 +++++
 rtl/acq_frame_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition frame scheduler.
package acq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    DISCARD = 2'd2,
    RUN     = 2'd3
  } acq_state_t;

  localparam int NUM_CH_DEF   = 16;
  localparam int PIPE_LAG_DEF = 2;
  localparam int SAMPLE_W     = 10;
  localparam int CH_W         = 4;

  // The master reports the channel whose command just went out; the result
  // on its data lines belongs to the command issued PIPE_LAG conversions ago.
  function automatic logic [CH_W-1:0] true_ch(input logic [5:0] ch,
                                               input int lag,
                                               input int nch);
    int t;
    t = (int'(ch) - lag) % nch;
    if (t < 0) t = t + nch;
    return t[CH_W-1:0];
  endfunction

endpackage

// File: rtl/acq_fifo.sv
// Small synchronous FIFO; pointers carry an extra MSB to tell full from empty.
// DEPTH must be a power of two, at least 2.
module acq_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head is forced to zero when empty so the stream outputs read as idle.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/acq_frame_scheduler.sv
// Sequences the dual-channel SPI master for continuous acquisition and packs
// channel-tagged A/B samples into a buffered valid/ready frame stream.
// Optional macro ACQ_TIMESTAMP_EN adds a 32-bit cycle timestamp per word (frm_ts).
//
//   state   | meaning
//   IDLE    | master held in reset, reset-length counter running
//   ARM     | master released, one-cycle trigger pulse
//   DISCARD | dropping pipeline-lag words and waiting for a channel-0 word
//   RUN     | pushing every conversion; leaves on frame end once enable drops
module acq_frame_scheduler
  import acq_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int PIPE_LAG   = PIPE_LAG_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_RST    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  output logic                  spi_rst,
  output logic                  spi_trig,
  input  logic                  spi_cs_b,
  input  logic [5:0]            spi_ch,
  input  logic [SAMPLE_W-1:0]   spi_out_a,
  input  logic [SAMPLE_W-1:0]   spi_out_b,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [2*SAMPLE_W-1:0] frm_data,
  output logic [CH_W-1:0]       frm_ch,
  output logic                  frm_sof,
  output logic                  frm_eof,
  output logic                  overflow,
`ifdef ACQ_TIMESTAMP_EN
  output logic [31:0]           frm_ts,
`endif
  output logic                  busy
);

  localparam int PAY_W = 2*SAMPLE_W + CH_W;
`ifdef ACQ_TIMESTAMP_EN
  localparam int WORD_W = PAY_W + 32;
`else
  localparam int WORD_W = PAY_W;
`endif
  localparam int RCW = (MIN_RST < 1)  ? 1 : $clog2(MIN_RST + 1);
  localparam int SKW = (PIPE_LAG < 1) ? 1 : $clog2(PIPE_LAG + 1);
  localparam logic [RCW-1:0]  RST_CNT_MAX = RCW'(MIN_RST);
  localparam logic [SKW-1:0]  SKIP_INIT   = SKW'(PIPE_LAG);
  localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);

  acq_state_t       r_state;
  logic [RCW-1:0]   r_rst_cnt;
  logic [SKW-1:0]   r_skip_cnt;
  logic             r_spi_rst;
  logic             r_spi_trig;
  logic             r_cs_d;
  logic             r_eoc;
  logic             r_push;
  logic             r_overflow;
  logic [WORD_W-1:0] r_word;

  logic              w_eoc;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CH_W-1:0]   w_tag;
  logic [PAY_W-1:0]  w_payload;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_fifo_dout;

  assign w_eoc     = spi_cs_b & ~r_cs_d;
  assign w_tag     = true_ch(spi_ch, PIPE_LAG, NUM_CH);
  assign w_payload = {spi_out_a, spi_out_b, w_tag};

`ifdef ACQ_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;

  // Free-running cycle counter sampled into each word at end-of-conversion.
  always_ff @(posedge CLK) begin
    if (RST) r_ts_cnt <= '0;
    else     r_ts_cnt <= r_ts_cnt + 32'd1;
  end

  assign w_word = {r_ts_cnt, w_payload};
  assign frm_ts = w_fifo_dout[WORD_W-1:PAY_W];
`else
  assign w_word = w_payload;
`endif

  // CS_b rising-edge detect; cs_d resets high so idle CS_b never looks like an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cs_d <= 1'b1;
      r_eoc  <= 1'b0;
    end else begin
      r_cs_d <= spi_cs_b;
      r_eoc  <= w_eoc;
    end
  end

  // Sequencer: master reset/trigger, lag discard, frame alignment and word capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rst_cnt  <= '0;
      r_skip_cnt <= '0;
      r_spi_rst  <= 1'b1;
      r_spi_trig <= 1'b0;
      r_push     <= 1'b0;
      r_word     <= '0;
    end else begin
      r_push     <= 1'b0;
      r_spi_trig <= 1'b0;
      case (r_state)
        IDLE: begin
          r_spi_rst <= 1'b1;
          if (r_rst_cnt != RST_CNT_MAX) r_rst_cnt <= r_rst_cnt + 1'b1;
          if (enable && (r_rst_cnt == RST_CNT_MAX)) begin
            r_state    <= ARM;
            r_spi_rst  <= 1'b0;
            r_spi_trig <= 1'b1;
          end
        end
        ARM: begin
          r_skip_cnt <= SKIP_INIT;
          if (!enable) begin
            r_state   <= IDLE;
            r_rst_cnt <= '0;
            r_spi_rst <= 1'b1;
          end else begin
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (!enable) begin
            r_state   <= IDLE;
            r_rst_cnt <= '0;
            r_spi_rst <= 1'b1;
          end else if (r_eoc) begin
            if (r_skip_cnt != '0) begin
              r_skip_cnt <= r_skip_cnt - 1'b1;
            end else if (w_tag == '0) begin
              // First good word of a frame: push it and stay aligned from here on.
              r_push  <= 1'b1;
              r_word  <= w_word;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (r_eoc) begin
            r_push <= 1'b1;
            r_word <= w_word;
            if (!enable && (w_tag == LAST_CH)) begin
              r_state   <= IDLE;
              r_rst_cnt <= '0;
              r_spi_rst <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a push that the FIFO could not take.
  always_ff @(posedge CLK) begin
    if (RST)                                     r_overflow <= 1'b0;
    else if (r_push && w_fifo_full && !w_pop)    r_overflow <= 1'b1;
  end

  acq_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_data  (r_word),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign frm_valid = ~w_fifo_empty;
  assign w_pop     = frm_valid & frm_ready;
  assign frm_ch    = w_fifo_dout[CH_W-1:0];
  assign frm_data  = w_fifo_dout[PAY_W-1:CH_W];
  assign frm_sof   = frm_valid & (frm_ch == '0);
  assign frm_eof   = frm_valid & (frm_ch == LAST_CH);

  // Reset reaches the master in the same cycle RST is asserted.
  assign spi_rst  = r_spi_rst | RST;
  assign spi_trig = r_spi_trig;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE);

endmodule
